// File: rtl/control_sequencer.sv
// control_sequencer
//   Multi-cycle control FSM for a small MIPS datapath. Accepts one 32-bit
//   instruction per inst_valid/inst_ready handshake, latches and decodes it,
//   then steps it through DECODE -> EXEC -> {MEM} -> {WB} -> IDLE.
//   Static datapath controls are held for the whole instruction and cleared
//   in IDLE. Write enables and the pulse outputs are each asserted for one cycle.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   inst_valid/inst/inst_ready  instruction handshake (ready only in IDLE)
//   zero, msb             ALU flags from the datapath (msb reserved)
//   inst_q                latched instruction
//   regwrite, memwrite    one-cycle write enables (WB / MEM)
//   regdst extop alusrc mem2reg aluctrl shiftctrl   static decode controls
//   branch_taken, illegal, done   one-cycle status pulses
//   retired               retired-instruction count (PERF_COUNT_EN only)
//
// Configuration
//   PERF_COUNT_EN  adds the CNT_W-bit retired counter and its output port.

module control_sequencer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid,
    input  logic [31:0] inst,
    output logic        inst_ready,
    input  logic        zero,
    input  logic        msb,
    output logic [31:0] inst_q,
    output logic        regwrite,
    output logic        regdst,
    output logic        extop,
    output logic        alusrc,
    output logic        memwrite,
    output logic        mem2reg,
    output logic [3:0]  aluctrl,
    output logic        shiftctrl,
    output logic        branch_taken,
    output logic        illegal,
    output logic        done
`ifdef PERF_COUNT_EN
    ,
    output logic [CNT_W-1:0] retired
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    typedef enum logic [2:0] {
        K_ILL,
        K_RTYPE,
        K_ADDI,
        K_LW,
        K_SW,
        K_BEQ
    } kind_t;

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    kind_t       dec_kind;
    logic [31:0] inst_reg_q, inst_reg_d;
    // {regdst, extop, alusrc, mem2reg, aluctrl[3:0], shiftctrl}
    logic [8:0]  ctrl_q, ctrl_d;
    logic [8:0]  dec_ctrl;

    // msb is reserved for future bltz/bgez support.
    logic unused_msb;
    assign unused_msb = msb;

    // Decode straight from the incoming word so the controls are already
    // registered when the FSM enters DECODE.
    always_comb begin
        dec_kind = K_ILL;
        dec_ctrl = '0;
        unique case (inst[31:26])
            6'b000000: begin
                unique case (inst[5:0])
                    6'b100000: begin dec_kind = K_RTYPE; dec_ctrl = 9'b1_0_0_0_0010_0; end
                    6'b100010: begin dec_kind = K_RTYPE; dec_ctrl = 9'b1_0_0_0_0110_0; end
                    6'b100100: begin dec_kind = K_RTYPE; dec_ctrl = 9'b1_0_0_0_0000_0; end
                    6'b100101: begin dec_kind = K_RTYPE; dec_ctrl = 9'b1_0_0_0_0001_0; end
                    6'b101010: begin dec_kind = K_RTYPE; dec_ctrl = 9'b1_0_0_0_0111_0; end
                    6'b000000: begin dec_kind = K_RTYPE; dec_ctrl = 9'b1_0_0_0_1000_1; end
                    default:   begin dec_kind = K_ILL;   dec_ctrl = '0;              end
                endcase
            end
            6'b001000: begin dec_kind = K_ADDI; dec_ctrl = 9'b0_1_1_0_0010_0; end
            6'b100011: begin dec_kind = K_LW;   dec_ctrl = 9'b0_1_1_1_0010_0; end
            6'b101011: begin dec_kind = K_SW;   dec_ctrl = 9'b0_1_1_0_0010_0; end
            6'b000100: begin dec_kind = K_BEQ;  dec_ctrl = 9'b0_1_0_0_0110_0; end
            default:   begin dec_kind = K_ILL;  dec_ctrl = '0;              end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        inst_reg_d   = inst_reg_q;
        ctrl_d       = ctrl_q;
        inst_ready   = 1'b0;
        regwrite     = 1'b0;
        memwrite     = 1'b0;
        branch_taken = 1'b0;
        illegal      = 1'b0;
        done         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                inst_ready = 1'b1;
                if (inst_valid) begin
                    inst_reg_d = inst;
                    kind_d     = dec_kind;
                    ctrl_d     = dec_ctrl;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                if (kind_q == K_ILL) begin
                    illegal = 1'b1;
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                unique case (kind_q)
                    K_LW, K_SW: state_d = S_MEM;
                    K_BEQ: begin
                        branch_taken = zero;
                        done         = 1'b1;
                        state_d      = S_IDLE;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (kind_q == K_SW) begin
                    memwrite = 1'b1;
                    done     = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                regwrite = 1'b1;
                done     = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Static controls fall back to zero whenever the instruction retires.
        if (state_q != S_IDLE && state_d == S_IDLE) begin
            ctrl_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            kind_q     <= K_ILL;
            inst_reg_q <= '0;
            ctrl_q     <= '0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            inst_reg_q <= inst_reg_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign inst_q = inst_reg_q;
    assign {regdst, extop, alusrc, mem2reg, aluctrl, shiftctrl} = ctrl_q;

`ifdef PERF_COUNT_EN
    logic [CNT_W-1:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (done && !illegal) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`else
    localparam int unsigned cnt_w_unused = CNT_W;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the stimulus side pushes the
// expected behaviour of each accepted instruction; a monitor observes the DUT
// every cycle and checks a transaction when its done pulse appears.

module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid = 1'b0;
    logic [31:0] inst = '0;
    logic        inst_ready;
    logic        zero = 1'b0;
    logic        msb = 1'b0;
    logic [31:0] inst_q;
    logic        regwrite, regdst, extop, alusrc, memwrite, mem2reg;
    logic [3:0]  aluctrl;
    logic        shiftctrl, branch_taken, illegal, done;
`ifdef PERF_COUNT_EN
    logic [31:0] retired;
`endif

    control_sequencer #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst(inst),
        .inst_ready(inst_ready), .zero(zero), .msb(msb), .inst_q(inst_q),
        .regwrite(regwrite), .regdst(regdst), .extop(extop), .alusrc(alusrc),
        .memwrite(memwrite), .mem2reg(mem2reg), .aluctrl(aluctrl),
        .shiftctrl(shiftctrl), .branch_taken(branch_taken), .illegal(illegal),
        .done(done)
`ifdef PERF_COUNT_EN
        , .retired(retired)
`endif
    );

    always #5 clk = ~clk;

    // Random ALU zero flag, changed just after each rising edge.
    always @(posedge clk) begin
        #1 zero = 1'($urandom_range(0, 1));
    end

    typedef struct {
        logic [31:0] inst;
        logic [8:0]  ctrl;
        int unsigned lat;
        bit          rw;
        bit          mw;
        bit          ill;
        bit          beq;
    } exp_t;

    exp_t        sbq[$];
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned legal_pushed = 0;
    bit          mon_en = 1'b1;
    bit          in_tx = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference behaviour from the instruction-level rules.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        logic [5:0] op, fn;
        logic [3:0] alu;
        bit rtype_ok;
        op = w[31:26];
        fn = w[5:0];
        e.inst = w; e.ctrl = '0; e.lat = 1; e.rw = 0; e.mw = 0; e.ill = 1; e.beq = 0;
        rtype_ok = 1'b1;
        alu = 4'd0;
        case (fn)
            6'd32:   alu = 4'b0010;
            6'd34:   alu = 4'b0110;
            6'd36:   alu = 4'b0000;
            6'd37:   alu = 4'b0001;
            6'd42:   alu = 4'b0111;
            6'd0:    alu = 4'b1000;
            default: rtype_ok = 1'b0;
        endcase
        if (op == 6'd0 && rtype_ok) begin
            e.ctrl = {1'b1, 3'b000, alu, (fn == 6'd0)};
            e.lat = 3; e.rw = 1; e.ill = 0;
        end else if (op == 6'd8) begin
            e.ctrl = {4'b0110, 4'b0010, 1'b0}; e.lat = 3; e.rw = 1; e.ill = 0;
        end else if (op == 6'd35) begin
            e.ctrl = {4'b0111, 4'b0010, 1'b0}; e.lat = 4; e.rw = 1; e.ill = 0;
        end else if (op == 6'd43) begin
            e.ctrl = {4'b0110, 4'b0010, 1'b0}; e.lat = 3; e.mw = 1; e.ill = 0;
        end else if (op == 6'd4) begin
            e.ctrl = {4'b0100, 4'b0110, 1'b0}; e.lat = 2; e.beq = 1; e.ill = 0;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [5:0]  fns [6];
        logic [5:0]  ops [4];
        int unsigned k;
        fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
        ops = '{6'd8, 6'd35, 6'd43, 6'd4};
        w = $urandom;
        k = $urandom_range(0, 11);
        if (k < 6) begin
            w[31:26] = 6'd0;
            w[5:0]   = fns[k];
        end else if (k < 10) begin
            w[31:26] = ops[k-6];
        end
        return w;
    endfunction

    task automatic send(input logic [31:0] w);
        bit ok = 1'b0;
        inst = w;
        inst_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (inst_ready) begin
                exp_t e;
                e = model(w);
                sbq.push_back(e);
                if (!e.ill) legal_pushed++;
                ok = 1'b1;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL accept_timeout: inst 0x%0h never accepted", w);
        end
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        inst = $urandom;
    endtask

    task automatic drain();
        int unsigned i = 0;
        while ((sbq.size() != 0 || in_tx) && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("sb_drain", sbq.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, inst_ready}, 32'd1);
        check({tag, "_inst_q"}, inst_q, 32'd0);
        check({tag, "_ctrl"}, {23'd0, regdst, extop, alusrc, mem2reg, aluctrl, shiftctrl}, 32'd0);
        check({tag, "_pulses"}, {27'd0, regwrite, memwrite, branch_taken, illegal, done}, 32'd0);
    endtask

    // Monitor: tracks the in-flight instruction and checks it on done.
    initial begin : monitor
        int unsigned cyc, rw_n, rw_at, mw_n, mw_at, ill_n, bt_n;
        bit ready_bad, ctrl_bad;
        logic [8:0] ctrl_first, ctrl_now;
        exp_t e;
        forever begin
            @(negedge clk);
            ctrl_now = {regdst, extop, alusrc, mem2reg, aluctrl, shiftctrl};
            if (!mon_en || !rst_n) begin
                in_tx = 1'b0;
            end else if (in_tx) begin
                cyc++;
                if (cyc == 1) ctrl_first = ctrl_now;
                else if (ctrl_now !== ctrl_first) ctrl_bad = 1'b1;
                if (inst_ready) ready_bad = 1'b1;
                if (regwrite) begin rw_n++; rw_at = cyc; end
                if (memwrite) begin mw_n++; mw_at = cyc; end
                if (illegal) ill_n++;
                if (branch_taken && !done) bt_n++;
                if (done || cyc > 10) begin
                    in_tx = 1'b0;
                    if (sbq.size() == 0) begin
                        n_checks++;
                        $display("FAIL sb_empty: done with no expected entry at %0t", $time);
                    end else begin
                        e = sbq.pop_front();
                        check("latency", cyc, e.lat);
                        check("inst_q", inst_q, e.inst);
                        check("ctrl", {23'd0, ctrl_first}, {23'd0, e.ctrl});
                        check("ctrl_held", {31'd0, ctrl_bad}, 32'd0);
                        check("ready_busy", {31'd0, ready_bad}, 32'd0);
                        check("regwrite_n", rw_n, e.rw ? 1 : 0);
                        if (e.rw) check("regwrite_at", rw_at, e.lat);
                        check("memwrite_n", mw_n, e.mw ? 1 : 0);
                        if (e.mw) check("memwrite_at", mw_at, e.lat);
                        check("illegal_n", ill_n, e.ill ? 1 : 0);
                        check("branch_taken", {31'd0, branch_taken}, {31'd0, e.beq & zero});
                        check("branch_early", bt_n, 0);
                    end
                end
            end
            if (mon_en && rst_n && !in_tx && inst_valid && inst_ready) begin
                check("idle_static", {20'd0, ctrl_now, regwrite, memwrite, done}, 32'd0);
                in_tx = 1'b1;
                cyc = 0; rw_n = 0; rw_at = 0; mw_n = 0; mw_at = 0; ill_n = 0; bt_n = 0;
                ready_bad = 1'b0; ctrl_bad = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] directed [7];
        bit          rw_seen;
        directed = '{32'h20050001, 32'h00021400, 32'h8C430000, 32'hAC430024,
                     32'h10000003, 32'hFC000000, 32'h10000003};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (directed[i]) send(directed[i]);
        for (int n = 0; n < 60; n++) begin
            send(rand_inst());
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();
`ifdef PERF_COUNT_EN
        check("retired_total", retired, legal_pushed);
`endif

        // Abort a lw during its MEM cycle.
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        inst = 32'h8C430000;
        inst_valid = 1'b1;
        @(negedge clk);
        check("rst_lw_ready", {31'd0, inst_ready}, 32'd1);
        @(posedge clk);
        #1 inst_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_lw_mem", {30'd0, mem2reg, memwrite}, 32'd2);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("midrst");
        rw_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (regwrite || done) rw_seen = 1'b1;
        end
        check("midrst_no_wb", {31'd0, rw_seen}, 32'd0);
`ifdef PERF_COUNT_EN
        check("retired_reset", retired, 32'd0);
`endif

        mon_en = 1'b1;
        @(posedge clk);
        #1;
        send(32'h20050001);
        send(32'hFC000000);
        send(32'h8C430000);
        send(32'hAC430024);
        send(32'h00021400);
        send(32'h10000003);
        drain();
`ifdef PERF_COUNT_EN
        check("retired_five", retired, 32'd5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
